uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/tx_baud_counter.sv | 44 ++++
 rtl/uart_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type constants and
// a counter-width helper used by the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a counter indexing n items; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period timing for the UART transmitter: an edge counter that wraps
// every prescale cycles, a bit_done strobe on its last cycle, and a
// data-bit counter that sits at zero outside the data phase.
module tx_baud_counter
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned BW         = cnt_width(DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          in_data,
  input  logic [4:0]    prescale,
  output logic          bit_done,
  output logic [BW-1:0] bit_cnt
);

  logic [4:0] edge_cnt;

  // prescale is never zero here; the transmitter maps 0 to 1 when latching
  assign bit_done = run && (edge_cnt == (prescale - 5'd1));

  // Cycle count within the current bit period
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      edge_cnt <= '0;
    end else if (bit_done) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  // Data bits already sent; held at zero so it is clear on entering DATA
  always_ff @(posedge clk) begin
    if (rst || !in_data) begin
      bit_cnt <= '0;
    end else if (bit_done) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a request, then serializes start bit, data
// bits LSB first, optional parity bit and stop bit on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned BW = cnt_width(DATA_WIDTH);

  uart_state_e           state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  par_bit;
  logic                  par_en_q;
  logic [4:0]            prescale_q;
  logic                  tx_out;
  logic                  busy;
  logic                  bit_done;
  logic [BW-1:0]         bit_cnt;
  logic                  last_data_bit;

  assign TX_OUT        = tx_out;
  assign BUSY          = busy;
  assign shift_next    = shift_reg >> 1;
  assign last_data_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

  tx_baud_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_baud (
    .clk      (CLK),
    .rst      (RST),
    .run      (state != IDLE),
    .in_data  (state == DATA),
    .prescale (prescale_q),
    .bit_done (bit_done),
    .bit_cnt  (bit_cnt)
  );

  // Frame sequencing, serializer and registered line/busy outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      par_en_q   <= 1'b0;
      prescale_q <= 5'd1;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (DATA_VALID) begin
            state      <= START;
            tx_out     <= 1'b0;
            busy       <= 1'b1;
            shift_reg  <= P_DATA;
            par_en_q   <= PAR_EN;
            par_bit    <= (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : ^P_DATA;
            prescale_q <= (PRESCALE == 5'd0) ? 5'd1 : PRESCALE;
          end
        end
        START: begin
          if (bit_done) begin
            state  <= DATA;
            tx_out <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (last_data_bit) begin
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              shift_reg <= shift_next;
              tx_out    <= shift_next[0];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state  <= IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
